onehot_decoder_seq: RTL and testbench
=====================================

Name: onehot_decoder_seq

Overview:
Sequenced binary-to-one-hot decoder, the counterpart of the team's 16-to-4 priority encoder. Binary codes arrive over a valid/ready handshake and queue in a small FIFO. Each code is replayed as a one-hot pulse of fixed length, with a fixed zero gap between consecutive pulses. An enable input gates the output and freezes sequencing, matching the encoder's enable semantics.

Parameters:
N_IN, 4, code width; output width is 2**N_IN (16 at default)
PULSE_LEN, 3, cycles each one-hot pattern is driven (>=1)
GAP_LEN, 1, zero cycles between consecutive pulses (>=1)
FIFO_DEPTH, 4, code queue depth (power of two, >=2)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = run and drive output; 0 = output forced 0, sequencer frozen
in_valid  input  1  code presented
in_code  input  N_IN  binary code
in_ready  output  1  FIFO can accept (= level != FIFO_DEPTH)
decoder_out  output  2**N_IN  one-hot pulse, or 0
busy  output  1  state != IDLE
fifo_level  output  clog2(FIFO_DEPTH)+1  entries queued

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-pulse), immediate with no clock edge needed:
  - decoder_out=0, busy=0, fifo_level=0, in_ready=1.
  - State IDLE, counter=0, FIFO pointers=0.
- Push: occurs on a rising edge when in_valid & in_ready.
  - in_ready is derived from the registered level only; no combinational path from in_valid.
  - A push is independent of enable; codes queue while enable=0.
- No bypass: a code pushed at edge k is popped no earlier than edge k+1.
- Push and pop in the same edge: level is unchanged.
- Full: in_ready=0, nothing is accepted, and in_code is ignored. A pop at that edge raises in_ready in the next cycle.
- Internal one-hot register oh_q. decoder_out = enable ? oh_q : 0, which is the only combinational output gating.
- Any N_IN-bit code is legal. oh_q <= 1 << code, so exactly one bit is set.
- State machine (states IDLE, DRIVE, GAP; all transitions qualified by enable=1; enable=0 holds state, counter and oh_q):
  - IDLE:
    - If FIFO is non-empty: pop head, oh_q <= 1<<head, cnt <= PULSE_LEN-1, go to DRIVE.
    - Otherwise stay in IDLE.
  - DRIVE:
    - If cnt != 0: cnt--.
    - If cnt == 0: oh_q <= 0, cnt <= GAP_LEN-1, go to GAP.
  - GAP:
    - If cnt != 0: cnt--.
    - If cnt == 0 and FIFO is non-empty: pop, load oh_q, cnt <= PULSE_LEN-1, go to DRIVE.
    - If cnt == 0 and FIFO is empty: go to IDLE.
- Timing:
  - Code accepted at edge k into an idle, empty block: decoder_out is valid after edges k+1 through k+PULSE_LEN.
  - Back-to-back pulses are separated by exactly GAP_LEN zero cycles.
- enable toggled mid-pulse: output reads 0 while enable is low. The remaining pulse cycles resume unchanged when enable rises, so the total driven cycles equal PULSE_LEN.
- busy covers both DRIVE and GAP.
- FIFO pointers wrap modulo FIFO_DEPTH. Level range is 0..FIFO_DEPTH.

Test Plan:
- Single code: reset, then enable=1 and push 4'h2 at edge 1 -> decoder_out=16'h0004 for 3 cycles after edges 2-4, then 0. busy=1 through the GAP cycle, then 0. fifo_level returns to 0.
- Back-to-back: push 4'h6, 4'hA, 4'hC on consecutive edges -> sequence 16'h0040 x3, 0 x1, 16'h0400 x3, 0 x1, 16'h1000 x3, 0. fifo_level peaks at 2. in_ready stays 1.
- Full: enable=0, present 5 codes (1, 3, 5, 7, 9) -> first 4 accepted, fifo_level=4, in_ready=0 while code 9 is held, decoder_out=0. Then raise enable -> pulses 16'h0002, 16'h0008, 16'h0020, 16'h0080 in order. Code 9 is accepted once in_ready rises.
- Enable freeze: push 4'hF, drop enable after the first pulse cycle for 2 cycles -> decoder_out reads 16'h8000, 0, 0, then 16'h8000 for 2 more cycles, then 0. Total of 3 driven cycles.
- Async reset mid-pulse: assert rst between edges while 16'h0100 is driven with 2 codes queued -> decoder_out=0, fifo_level=0, in_ready=1, busy=0 immediately. After release, no stale pulse appears.
- Full plus simultaneous pop: FIFO full and GAP ending with in_valid=1 -> no push at that edge and level drops to 3. in_ready=1 in the next cycle and the code is accepted at the following edge.

Source files
------------

// File: rtl/onehot_decoder_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder_seq_if
// Description : Code handshake (valid/ready + binary code) for the decoder.
// Revision    : 1.0
// ============================================================================
interface onehot_decoder_seq_if #(
    parameter int N_IN = 4
);
    logic            in_valid;
    logic [N_IN-1:0] in_code;
    logic            in_ready;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder_seq
// Description : Queued binary-to-one-hot decoder emitting fixed-length pulses
//               separated by fixed zero gaps, gated and frozen by enable.
// Revision    : 1.0
// ============================================================================
module onehot_decoder_seq #(
    parameter int N_IN       = 4,
    parameter int PULSE_LEN  = 3,
    parameter int GAP_LEN    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire                            clk,
    input  wire                            rst,
    input  wire                            enable,
    onehot_decoder_seq_if.slave            in_if,
    output logic [2**N_IN-1:0]             decoder_out,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam int OUT_W   = 2**N_IN;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [LEVEL_W-1:0] C_FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   C_PULSE_CNT  = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]   C_GAP_CNT    = CNT_W'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Code FIFO
    // ------------------------------------------------------------------
    logic [N_IN-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic [N_IN-1:0]    w_head;

    // Ready depends only on the registered level, never on in_valid.
    assign w_ready     = (level_q != C_FULL_LEVEL);
    assign w_push      = in_if.in_valid & w_ready;
    assign w_not_empty = (level_q != '0);
    assign w_head      = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_if.in_code;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Pulse sequencer
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   oh_q, oh_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oh_d    = oh_q;
        w_pop   = 1'b0;
        // Deasserted enable holds state, counter and pattern untouched.
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_not_empty) begin
                        w_pop   = 1'b1;
                        oh_d    = OUT_W'(1) << w_head;
                        cnt_d   = C_PULSE_CNT;
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        oh_d    = '0;
                        cnt_d   = C_GAP_CNT;
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (w_not_empty) begin
                        w_pop   = 1'b1;
                        oh_d    = OUT_W'(1) << w_head;
                        cnt_d   = C_PULSE_CNT;
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    oh_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oh_q    <= oh_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_if.in_ready = w_ready;
    assign decoder_out    = enable ? oh_q : '0;
    assign busy           = (state_q != ST_IDLE);
    assign fifo_level     = level_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_decoder_seq.sv
`default_nettype none
// Testbench for onehot_decoder_seq: directed scenarios with literal
// expectations plus randomized traffic against a queue-based schedule model.
module tb_onehot_decoder_seq;

    localparam int N_IN       = 4;
    localparam int PULSE_LEN  = 3;
    localparam int GAP_LEN    = 1;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] decoder_out;
    logic        busy;
    logic [2:0]  fifo_level;

    onehot_decoder_seq_if #(.N_IN(N_IN)) ifc ();

    onehot_decoder_seq #(
        .N_IN      (N_IN),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_if      (ifc),
        .decoder_out(decoder_out),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of codes plus a schedule of output values still to be shown.
    // Each enabled edge retires the current schedule slot; when the schedule
    // runs dry, the oldest queued code expands into PULSE_LEN one-hot slots
    // followed by GAP_LEN zero slots.
    logic [3:0]  m_fifo[$];
    logic [15:0] m_sched[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            m_sched.delete();
        end else begin
            bit         can_push;
            logic [3:0] c;
            can_push = (m_fifo.size() != FIFO_DEPTH);
            if (enable) begin
                if (m_sched.size() > 0) void'(m_sched.pop_front());
                if (m_sched.size() == 0 && m_fifo.size() > 0) begin
                    c = m_fifo.pop_front();
                    for (int i = 0; i < PULSE_LEN; i++) m_sched.push_back(16'(1) << c);
                    for (int i = 0; i < GAP_LEN; i++) m_sched.push_back(16'h0);
                end
            end
            if (ifc.in_valid && can_push) m_fifo.push_back(ifc.in_code);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [15:0] cur;
            cur = (m_sched.size() > 0) ? m_sched[0] : 16'h0;
            chk("model_out",   decoder_out, enable ? cur : 16'h0);
            chk("model_busy",  busy, m_sched.size() > 0);
            chk("model_level", fifo_level, m_fifo.size());
            chk("model_ready", ifc.in_ready, m_fifo.size() != FIFO_DEPTH);
        end
    end

    // Records the order of distinct pulses during the full-FIFO scenario.
    bit          rec_en = 0;
    logic [15:0] seen[$];
    always @(negedge clk) begin
        if (rec_en && decoder_out != 16'h0) begin
            if (seen.size() == 0 || seen[$] != decoder_out) seen.push_back(decoder_out);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i;
        enable       = 1'b1;
        ifc.in_valid = 1'b0;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && fifo_level == 0) break;
        end
        chk("drain_done", (i < 300), 1);
        cyc();
    endtask

    task automatic wait_accept(input string name);
        int  i;
        bit  r;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            r = ifc.in_ready;
            cyc();
            if (r) break;
        end
        chk(name, (i < 50), 1);
    endtask

    logic [15:0] single_out[5]  = '{16'h0004, 16'h0004, 16'h0004, 16'h0000, 16'h0000};
    logic        single_busy[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] bb_out[12] = '{16'h0040, 16'h0040, 16'h0040, 16'h0000,
                                16'h0400, 16'h0400, 16'h0400, 16'h0000,
                                16'h1000, 16'h1000, 16'h1000, 16'h0000};
    logic [15:0] frz_out[6] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h0000};
    logic [15:0] full_seq[6] = '{16'h0002, 16'h0008, 16'h0020, 16'h0080, 16'h0200, 16'h0800};
    logic [3:0]  full_codes[4] = '{4'h1, 4'h3, 4'h5, 4'h7};

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        enable       = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_code  = '0;

        // Reset state
        #2;
        chk("rst_out",   decoder_out, 16'h0);
        chk("rst_busy",  busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", ifc.in_ready, 1);
        #10;
        rst = 1'b0;
        cyc();

        // Single code
        enable = 1'b1; ifc.in_valid = 1'b1; ifc.in_code = 4'h2;
        cyc();
        ifc.in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("single_out",  decoder_out, single_out[k]);
            chk("single_busy", busy, single_busy[k]);
        end
        chk("single_level", fifo_level, 0);
        cyc();

        // Back-to-back codes on consecutive edges
        ifc.in_valid = 1'b1; ifc.in_code = 4'h6;
        cyc();
        ifc.in_code = 4'hA;
        cyc();
        ifc.in_code = 4'hC;
        cyc();
        ifc.in_valid = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            chk("b2b_out", decoder_out, bb_out[k]);
        end
        drain();

        // Full FIFO while disabled, then release with simultaneous pops
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ifc.in_valid = 1'b1; ifc.in_code = full_codes[k];
            cyc();
        end
        ifc.in_code = 4'h9;
        cyc();
        cyc();
        @(negedge clk);
        chk("full_level", fifo_level, 4);
        chk("full_ready", ifc.in_ready, 0);
        chk("full_out",   decoder_out, 16'h0);
        cyc();
        seen.delete();
        rec_en = 1'b1;
        enable = 1'b1;
        wait_accept("accept_9_timeout");
        ifc.in_code = 4'hB;
        wait_accept("accept_b_timeout");
        drain();
        rec_en = 1'b0;
        chk("full_seq_len", seen.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk("full_seq", (k < seen.size()) ? seen[k] : 16'h0, full_seq[k]);
        end

        // Enable freeze mid-pulse
        ifc.in_valid = 1'b1; ifc.in_code = 4'hF;
        cyc();
        ifc.in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("freeze_out", decoder_out, frz_out[k]);
            if (k == 0) begin #1; enable = 1'b0; end
            if (k == 2) begin #1; enable = 1'b1; end
        end
        drain();

        // Asynchronous reset mid-pulse with two codes queued
        ifc.in_valid = 1'b1; ifc.in_code = 4'h8;
        cyc();
        ifc.in_code = 4'h1;
        cyc();
        ifc.in_code = 4'h2;
        cyc();
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_out",   decoder_out, 16'h0100);
        chk("pre_rst_level", fifo_level, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out",   decoder_out, 16'h0);
        chk("arst_level", fifo_level, 0);
        chk("arst_ready", ifc.in_ready, 1);
        chk("arst_busy",  busy, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_out", decoder_out, 16'h0);
        end
        cyc();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            enable       = ($urandom_range(0, 4) != 0);
            ifc.in_valid = $urandom_range(0, 1);
            ifc.in_code  = 4'($urandom);
            cyc();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
